// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - ALU issue stage: register file, PC and IDLE/READ/EXEC/WB dispatch FSM
// Optional ALU_DISPATCH_FAST_EN drops READ and samples operands at the transfer edge.
module alu_dispatch #(
  parameter int bit_width = 32,
  parameter int NREGS     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [31:0]          instr,
  output logic [3:0]           alu_op,
  output logic [bit_width-1:0] alu_a,
  output logic [bit_width-1:0] alu_b,
  output logic [bit_width-1:0] alu_pc,
  input  logic [bit_width-1:0] alu_r,
  output logic [bit_width-1:0] pc,
  output logic                 wb_valid,
  output logic [3:0]           wb_addr,
  output logic [bit_width-1:0] wb_data,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t               state_q, state_d;
  logic [bit_width-1:0] regs_q [NREGS];
  logic [bit_width-1:0] pc_q, pc_d, pcn_q;
  logic [bit_width-1:0] a_q, b_q, r_q;
  logic [bit_width-1:0] a_d, b_d;
  logic [3:0]           op_q, rd_w;
  logic                 err_q;
  logic                 xfer, load_ops, is_branch, is_illegal;
  logic [3:0]           src_op, src_ra, src_rb;
  logic                 src_imm_en;
  logic [14:0]          src_imm;

  assign xfer = instr_valid && (state_q == IDLE);

`ifdef ALU_DISPATCH_FAST_EN
  logic [3:0] rd_q;

  assign {src_op, src_ra, src_rb, src_imm_en, src_imm} = {instr[31:28], instr[23:0]};
  assign rd_w     = rd_q;
  assign load_ops = xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= 4'd0;
    end else if (xfer) begin
      rd_q <= instr[27:24];
    end
  end
`else
  logic [31:0] instr_q;

  assign {src_op, src_ra, src_rb, src_imm_en, src_imm} = {instr_q[31:28], instr_q[23:0]};
  assign rd_w     = instr_q[27:24];
  assign load_ops = (state_q == READ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= 32'd0;
    end else if (xfer) begin
      instr_q <= instr;
    end
  end
`endif

  // Operand fetch; r0 and out-of-range indices read as zero.
  always_comb begin
    a_d = '0;
    b_d = bit_width'(src_imm);
    if (src_ra != 4'd0 && int'(src_ra) < NREGS) a_d = regs_q[src_ra];
    if (!src_imm_en) begin
      b_d = '0;
      if (src_rb != 4'd0 && int'(src_rb) < NREGS) b_d = regs_q[src_rb];
    end
  end

  assign is_branch  = (op_q == 4'd12) || (op_q == 4'd13);
  assign is_illegal = (op_q >= 4'd14);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
`ifdef ALU_DISPATCH_FAST_EN
          state_d = EXEC;
`else
          state_d = READ;
`endif
        end
      end
      READ: state_d = EXEC;
      EXEC: state_d = WB;
      WB: begin
        state_d = IDLE;
        pc_d    = is_branch ? r_q : pc_q + bit_width'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      pcn_q   <= '0;
      op_q    <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      // Follows the PC one step ahead so alu_pc is pc+1 in whatever state comes next.
      pcn_q   <= pc_d + bit_width'(1);
      if (load_ops) begin
        op_q <= src_op;
        a_q  <= a_d;
        b_q  <= b_d;
      end
      if (state_q == EXEC) r_q <= alu_r;
      if (state_q == WB && is_illegal) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (state_q == WB && !is_branch && !is_illegal &&
                 rd_w != 4'd0 && int'(rd_w) < NREGS) begin
      regs_q[rd_w] <= r_q;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_pc      = pcn_q;
  assign pc          = pc_q;
  assign err         = err_q;
  assign wb_valid    = (state_q == WB) && !is_illegal;
  assign wb_addr     = (state_q == WB && !is_branch && !is_illegal) ? rd_w : 4'd0;
  assign wb_data     = wb_valid ? r_q : '0;

endmodule

// File: tb/tb_alu_dispatch.sv
// tb/tb_alu_dispatch.sv - self-checking bench for alu_dispatch with a bench-side combinational ALU
`timescale 1ns/1ps
module tb_alu_dispatch;
`ifdef ALU_DISPATCH_FAST_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        instr_ready, wb_valid, err;
  logic [3:0]  alu_op, wb_addr;
  logic [31:0] alu_a, alu_b, alu_pc, alu_r, pc, wb_data;

  int n_checks = 0, n_fail = 0;
  int wb_count = 0, cnt, prev, nrdy;
  logic [31:0] last_wb_data = 32'd0;
  logic [3:0]  last_wb_addr = 4'd0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, b, p);
    case (op)
      4'd0:    return b;
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd11:   return (a < b) ? 32'hFFFF_FFFF : 32'd0;
      4'd12:   return (a != 32'd0) ? b : p;
      4'd13:   return (a == 32'd0) ? b : p;
      default: return a;
    endcase
  endfunction

  assign alu_r = alu_fn(alu_op, alu_a, alu_b, alu_pc);

  alu_dispatch #(.bit_width(32), .NREGS(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_pc(alu_pc),
    .alu_r(alu_r), .pc(pc), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .err(err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Architectural model: register array, PC, sticky error, one instruction in flight.
  logic [31:0] m_regs [16];
  logic [31:0] m_pc;
  logic        m_err;
  int          busy;
  logic        e_wbv, e_wreg, e_ill;
  logic [3:0]  e_addr, e_op;
  logic [31:0] e_data, e_pc, e_a, e_b, e_pcp1;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
      m_pc = 32'd0; m_err = 1'b0; busy = 0;
    end else if (busy > 0) begin
      check("ready_low_busy", instr_ready, 1'b0);
      if (busy == 2) begin
        check("alu_op", alu_op, e_op);
        check("alu_a", alu_a, e_a);
        check("alu_b", alu_b, e_b);
        check("alu_pc", alu_pc, e_pcp1);
      end
      if (busy == 1) begin
        check("wb_valid", wb_valid, e_wbv);
        if (e_wbv) begin
          check("wb_addr", wb_addr, e_addr);
          check("wb_data", wb_data, e_data);
        end
        check("pc_in_wb", pc, m_pc);
        if (e_wreg) m_regs[e_addr] = e_data;
        m_pc = e_pc;
        if (e_ill) m_err = 1'b1;
      end else begin
        check("wb_valid_quiet", wb_valid, 1'b0);
      end
      busy--;
    end else begin
      check("ready_idle", instr_ready, 1'b1);
      check("wb_valid_idle", wb_valid, 1'b0);
      check("pc_idle", pc, m_pc);
      check("err_idle", err, m_err);
      if (instr_valid) begin
        e_op   = instr[31:28];
        e_a    = m_regs[instr[23:20]];
        e_b    = instr[15] ? {17'd0, instr[14:0]} : m_regs[instr[19:16]];
        e_pcp1 = m_pc + 32'd1;
        e_data = alu_fn(e_op, e_a, e_b, e_pcp1);
        e_ill  = (e_op >= 4'd14);
        if (e_ill) begin
          e_wbv = 1'b0; e_wreg = 1'b0; e_addr = 4'd0; e_pc = e_pcp1;
        end else if (e_op >= 4'd12) begin
          e_wbv = 1'b1; e_wreg = 1'b0; e_addr = 4'd0; e_pc = e_data;
        end else begin
          e_wbv = 1'b1; e_addr = instr[27:24]; e_wreg = (instr[27:24] != 4'd0); e_pc = e_pcp1;
        end
        busy = LAT;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      wb_count++;
      last_wb_data = wb_data;
      last_wb_addr = wb_addr;
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (instr_ready) begin ok = 1'b1; break; end
    end
    check("idle_timeout", ok, 1'b1);
  endtask

  task automatic issue(input logic [3:0] op, rd, ra, rb, input logic ie, input logic [14:0] imm);
    @(posedge clk); #1;
    instr = {op, rd, ra, rb, ie, imm};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = $urandom;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_pc", pc, 32'd0);
    check("rst_ready", instr_ready, 1'b1);
    check("rst_err", err, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_addr", wb_addr, 4'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_alu_op", alu_op, 4'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_pc", alu_pc, 32'd0);
    rst_n = 1'b1;

    issue(4'd1, 4'd1, 4'd0, 4'd0, 1'b1, 15'd5);
    check("add_data", last_wb_data, 32'd5);
    check("add_addr", last_wb_addr, 4'd1);
    check("add_pc", pc, 32'd1);
    issue(4'd2, 4'd2, 4'd1, 4'd0, 1'b1, 15'd3);
    check("sub_data", last_wb_data, 32'd2);
    issue(4'd11, 4'd3, 4'd2, 4'd1, 1'b0, 15'd0);
    check("cmp_less_data", last_wb_data, 32'hFFFF_FFFF);
    issue(4'd12, 4'd9, 4'd3, 4'd0, 1'b1, 15'h40);
    check("out_t_pc", pc, 32'h40);
    check("out_t_addr", last_wb_addr, 4'd0);
    issue(4'd13, 4'd0, 4'd3, 4'd0, 1'b1, 15'h10);
    check("out_f_pc", pc, 32'h41);

    cnt = wb_count;
    issue(4'd15, 4'd5, 4'd1, 4'd1, 1'b0, 15'd0);
    issue(4'd14, 4'd5, 4'd1, 4'd1, 1'b1, 15'd9);
    check("illegal_no_wb", wb_count, cnt);
    check("illegal_err", err, 1'b1);
    check("illegal_pc", pc, 32'h43);
    issue(4'd1, 4'd4, 4'd1, 4'd0, 1'b1, 15'd1);
    check("add_after_err", last_wb_data, 32'd6);
    check("err_sticky", err, 1'b1);

    cnt = wb_count;
    issue(4'd1, 4'd0, 4'd0, 4'd0, 1'b1, 15'd7);
    check("r0_write_pulse", wb_count, cnt + 1);
    check("r0_write_data", last_wb_data, 32'd7);
    issue(4'd4, 4'd5, 4'd0, 4'd0, 1'b0, 15'd0);
    check("r0_reads_zero", last_wb_data, 32'd0);

    issue(4'd12, 4'd0, 4'd3, 4'd3, 1'b0, 15'd0);
    check("jump_all_ones", pc, 32'hFFFF_FFFF);
    issue(4'd1, 4'd7, 4'd0, 4'd0, 1'b1, 15'd9);
    check("pc_wrap", pc, 32'd0);

    @(posedge clk); #1;
    instr = {4'd1, 4'd6, 4'd6, 4'd0, 1'b1, 15'd1};
    instr_valid = 1'b1;
    prev = -1; nrdy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        if (prev >= 0) check("ready_spacing", i - prev, LAT + 1);
        prev = i; nrdy++;
      end
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    wait_idle();
    check("burst_r6", last_wb_data, nrdy);

    cnt = wb_count;
    @(posedge clk); #1;
    instr = {4'd1, 4'd8, 4'd0, 4'd0, 1'b1, 15'd3};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (LAT - 2) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("exec_rst_pc", pc, 32'd0);
    check("exec_rst_err", err, 1'b0);
    check("exec_rst_ready", instr_ready, 1'b1);
    rst_n = 1'b1;
    wait_idle();
    check("exec_rst_no_wb", wb_count, cnt);

    for (int k = 1; k < 16; k++) begin
      issue(4'd4, 4'd0, 4'(k), 4'(k), 1'b0, 15'd0);
      check("reg_reset_zero", last_wb_data, 32'd0);
    end
    check("pc_after_reads", pc, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
